// File: rtl/synth_pkg.sv
// synth_pkg: PS/2 note-code table, prefix bytes and parser state shared by the voice allocator.
package synth_pkg;
  localparam logic [7:0] BRK_PREFIX = 8'hF0;
  localparam logic [7:0] EXT_PREFIX = 8'hE0;
  localparam int NUM_NOTES = 26;
  // The last six slots are reserved; they hold BRK_PREFIX, which is_note never accepts.
  localparam logic [NUM_NOTES-1:0][7:0] NOTE_CODES = {
    8'h15, 8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34, 8'h35,
    8'h33, 8'h3B, 8'h43, 8'h42, 8'h44, 8'h4B, 8'h4D, 8'h4C, 8'h52, 8'h5B,
    {6{BRK_PREFIX}}
  };
  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXTBRK} ps2_state_t;
  function automatic logic is_note(input logic [7:0] c);
    is_note = 1'b0;
    for (int i = 0; i < NUM_NOTES; i++)
      if (c != BRK_PREFIX && NOTE_CODES[i] == c) is_note = 1'b1;
  endfunction
endpackage

// File: rtl/ps2_code_parser.sv
// ps2_code_parser: PS/2 prefix FSM turning raw bytes into note make/break strobes.
module ps2_code_parser
  import synth_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_code,
  input  logic       key_valid,
  output logic       make_strb,
  output logic       brk_strb,
  output logic [7:0] code
);
  ps2_state_t state_q, state_d;
  always_comb begin
    state_d = state_q;
    make_strb = 1'b0;
    brk_strb = 1'b0;
    code = key_code;
    if (key_valid && !rst)
      case (state_q)
        S_IDLE: begin
          state_d = key_code == BRK_PREFIX ? S_BRK : key_code == EXT_PREFIX ? S_EXT : S_IDLE;
          make_strb = is_note(key_code);
        end
        S_BRK: begin
          state_d = key_code == BRK_PREFIX ? S_BRK : S_IDLE;
          brk_strb = is_note(key_code);
        end
        S_EXT:   state_d = key_code == BRK_PREFIX ? S_EXTBRK : S_IDLE;
        default: state_d = S_IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: maps PS/2 make/break codes onto NUM_VOICES held notes, stealing the oldest when full.
// Optional sustain pedal behaviour is enabled with VOICE_SUSTAIN_EN.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int         NUM_VOICES = 3,
  parameter logic [7:0] IDLE_CODE  = 8'hF0
) (
  input  logic                    CLK_50,
  input  logic                    reset,
  input  logic [7:0]              key_code,
  input  logic                    key_valid,
  input  logic                    sustain,
  output logic [8*NUM_VOICES-1:0] voice_codes,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic                    steal_pulse
);
  localparam int AW = $clog2(NUM_VOICES);
  localparam logic [AW-1:0] AGE_MAX = AW'(NUM_VOICES - 1);
  logic make_strb, brk_strb, hit, free, steal_q, steal_d;
  logic [7:0] code;
  logic [7:0] code_q [NUM_VOICES];
  logic [7:0] code_d [NUM_VOICES];
  logic [AW-1:0] age_q [NUM_VOICES];
  logic [AW-1:0] age_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] active_q, active_d;
  int free_idx, old_idx, tgt;
`ifdef VOICE_SUSTAIN_EN
  logic [NUM_VOICES-1:0] pend_q, pend_d;
  logic sus_q;
`else
  logic unused_sustain;
  assign unused_sustain = sustain;
`endif
  ps2_code_parser u_parser (
    .clk(CLK_50), .rst(reset), .key_code(key_code), .key_valid(key_valid),
    .make_strb(make_strb), .brk_strb(brk_strb), .code(code)
  );
  always_comb begin
    code_d = code_q;
    age_d = age_q;
    steal_d = 1'b0;
    hit = 1'b0;
    free = 1'b0;
    free_idx = 0;
    old_idx = 0;
`ifdef VOICE_SUSTAIN_EN
    pend_d = pend_q;
    for (int i = 0; i < NUM_VOICES; i++)
      if (sus_q && !sustain && pend_q[i]) begin
        code_d[i] = IDLE_CODE;
        age_d[i] = '0;
        pend_d[i] = 1'b0;
      end
`endif
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (code_d[i] == IDLE_CODE) begin
        free = 1'b1;
        free_idx = i;
      end
      if (make_strb && code_d[i] == code) begin
        hit = 1'b1;
`ifdef VOICE_SUSTAIN_EN
        pend_d[i] = 1'b0;
`endif
      end
    end
    for (int i = 0; i < NUM_VOICES; i++)
      if (age_d[i] > age_d[old_idx]) old_idx = i;
    tgt = free ? free_idx : old_idx;
    if (make_strb && !hit) begin
      for (int i = 0; i < NUM_VOICES; i++)
        if (i == tgt) begin
          code_d[i] = code;
          age_d[i] = '0;
`ifdef VOICE_SUSTAIN_EN
          pend_d[i] = 1'b0;
`endif
        end else if (code_d[i] != IDLE_CODE && age_d[i] != AGE_MAX) age_d[i] = age_d[i] + 1'b1;
      steal_d = !free;
    end
    for (int i = 0; i < NUM_VOICES; i++)
      if (brk_strb && code_d[i] == code) begin
`ifdef VOICE_SUSTAIN_EN
        if (sustain) pend_d[i] = 1'b1;
        else begin
          code_d[i] = IDLE_CODE;
          age_d[i] = '0;
          pend_d[i] = 1'b0;
        end
`else
        code_d[i] = IDLE_CODE;
        age_d[i] = '0;
`endif
      end
    for (int i = 0; i < NUM_VOICES; i++) active_d[i] = code_d[i] != IDLE_CODE;
  end
  always_ff @(posedge CLK_50)
    if (reset) begin
      code_q <= '{default: IDLE_CODE};
      age_q <= '{default: '0};
      active_q <= '0;
      steal_q <= 1'b0;
`ifdef VOICE_SUSTAIN_EN
      pend_q <= '0;
      sus_q <= 1'b0;
`endif
    end else begin
      code_q <= code_d;
      age_q <= age_d;
      active_q <= active_d;
      steal_q <= steal_d;
`ifdef VOICE_SUSTAIN_EN
      pend_q <= pend_d;
      sus_q <= sustain;
`endif
    end
  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_out
    assign voice_codes[8*v +: 8] = code_q[v];
  end
  assign voice_active = active_q;
  assign steal_pulse = steal_q;
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed scenarios plus random byte streams checked against a timestamp-based voice model.
module tb_voice_allocator;
  localparam int N = 3;
  localparam logic [7:0] IDLE = 8'hF0;
  logic CLK_50 = 1'b0;
  logic reset, key_valid, sustain;
  logic [7:0] key_code;
  logic [8*N-1:0] voice_codes;
  logic [N-1:0] voice_active;
  logic steal_pulse;
  int checks = 0;
  int errors = 0;
  logic [7:0] notes [20] = '{8'h15, 8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C, 8'h34, 8'h35,
                             8'h33, 8'h3B, 8'h43, 8'h42, 8'h44, 8'h4B, 8'h4D, 8'h4C, 8'h52, 8'h5B};
  logic [7:0] m_code [N];
  int m_stamp [N];
  bit m_pend [N];
  int m_allocs, m_pfx;
  bit m_steal, m_sus;

  voice_allocator #(.NUM_VOICES(N), .IDLE_CODE(IDLE)) dut (
    .CLK_50(CLK_50), .reset(reset), .key_code(key_code), .key_valid(key_valid),
    .sustain(sustain), .voice_codes(voice_codes), .voice_active(voice_active),
    .steal_pulse(steal_pulse)
  );

  always #5 CLK_50 = ~CLK_50;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit known_note(input logic [7:0] c);
    foreach (notes[i]) if (notes[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  // Age = allocations made since this voice was filled, capped at N-1.
  function automatic int age_of(input int i);
    return (m_allocs - m_stamp[i] > N - 1) ? N - 1 : m_allocs - m_stamp[i];
  endfunction

  task automatic model_make(input logic [7:0] c);
    int t = -1;
    foreach (m_code[i]) if (m_code[i] == c) begin
      m_pend[i] = 1'b0;
      return;
    end
    foreach (m_code[i]) if (t < 0 && m_code[i] == IDLE) t = i;
    m_steal = t < 0;
    if (t < 0) begin
      t = 0;
      foreach (m_code[i]) if (age_of(i) > age_of(t)) t = i;
    end
    m_allocs++;
    m_code[t] = c;
    m_stamp[t] = m_allocs;
    m_pend[t] = 1'b0;
  endtask

  task automatic model_break(input logic [7:0] c);
    foreach (m_code[i]) if (m_code[i] == c) begin
`ifdef VOICE_SUSTAIN_EN
      if (sustain) m_pend[i] = 1'b1;
      else begin
        m_code[i] = IDLE;
        m_pend[i] = 1'b0;
      end
`else
      m_code[i] = IDLE;
`endif
    end
  endtask

  task automatic model_step();
    m_steal = 1'b0;
    if (reset) begin
      foreach (m_code[i]) begin
        m_code[i] = IDLE;
        m_pend[i] = 1'b0;
      end
      m_pfx = 0;
      m_sus = 1'b0;
      return;
    end
`ifdef VOICE_SUSTAIN_EN
    if (m_sus && !sustain)
      foreach (m_code[i]) if (m_pend[i]) begin
        m_code[i] = IDLE;
        m_pend[i] = 1'b0;
      end
`endif
    if (key_valid) begin
      bit n;
      n = known_note(key_code);
      case (m_pfx)
        0: if (key_code == 8'hF0) m_pfx = 1;
           else if (key_code == 8'hE0) m_pfx = 2;
           else if (n) model_make(key_code);
        1: if (key_code != 8'hF0) begin
             if (n) model_break(key_code);
             m_pfx = 0;
           end
        2: m_pfx = key_code == 8'hF0 ? 3 : 0;
        default: m_pfx = 0;
      endcase
    end
    m_sus = sustain;
  endtask

  function automatic logic [31:0] exp_codes();
    logic [31:0] r = '0;
    foreach (m_code[i]) r[8*i +: 8] = m_code[i];
    return r;
  endfunction

  function automatic logic [31:0] exp_active();
    logic [31:0] r = '0;
    foreach (m_code[i]) r[i] = m_code[i] != IDLE;
    return r;
  endfunction

  task automatic cyc(input logic v, input logic [7:0] c, input logic s, input logic r);
    @(negedge CLK_50);
    key_valid = v;
    key_code = c;
    sustain = s;
    reset = r;
    @(posedge CLK_50);
    model_step();
    #1;
    check("codes", voice_codes, exp_codes());
    check("active", voice_active, exp_active());
    check("steal", steal_pulse, m_steal);
  endtask

  task automatic key(input logic [7:0] c);
    cyc(1'b1, c, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] c;
    logic v, s, r;
    int sel;
    reset = 1'b1;
    key_valid = 1'b0;
    key_code = 8'h00;
    sustain = 1'b0;
    m_allocs = 0;
    foreach (m_stamp[i]) m_stamp[i] = 0;
    cyc(1'b1, 8'h1C, 1'b0, 1'b1);
    check("reset_codes", voice_codes, 32'hF0F0F0);
    check("reset_active", voice_active, 32'h0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    key(8'h1C);
    check("t1_first", voice_codes, 32'hF0F01C);
    key(8'h2B);
    key(8'h33);
    check("t1_codes", voice_codes, 32'h332B1C);
    check("t1_active", voice_active, 32'h7);
    key(8'h42);
    check("t2_steal_codes", voice_codes, 32'h332B42);
    check("t2_steal_pulse", steal_pulse, 32'h1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("t2_pulse_end", steal_pulse, 32'h0);
    do_reset();
    key(8'h1C);
    for (int i = 0; i < 5; i++) key(8'h1C);
    check("t3_repeat", voice_codes, 32'hF0F01C);
    key(8'hF0);
    check("t3_prefix_only", voice_codes, 32'hF0F01C);
    key(8'h1C);
    check("t3_release", voice_codes, 32'hF0F0F0);
    check("t3_inactive", voice_active, 32'h0);
    do_reset();
    key(8'hE0); key(8'h75);
    key(8'hE0); key(8'hF0); key(8'h75);
    key(8'h29);
    check("t4_ignored", voice_codes, 32'hF0F0F0);
    key(8'h2B);
    check("t4_make", voice_codes, 32'hF0F02B);
    do_reset();
    key(8'hF0);
    do_reset();
    key(8'h1C);
    check("t5_prefix_abandoned", voice_codes, 32'hF0F01C);
`ifdef VOICE_SUSTAIN_EN
    do_reset();
    cyc(1'b1, 8'h2B, 1'b1, 1'b0);
    cyc(1'b1, 8'hF0, 1'b1, 1'b0);
    cyc(1'b1, 8'h2B, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("t6_sustained", voice_codes, 32'hF0F02B);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("t6_released", voice_codes, 32'hF0F0F0);
`endif
    s = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      v = $urandom_range(0, 99) < 60;
      sel = $urandom_range(0, 9);
      c = sel < 6 ? notes[$urandom_range(0, (k % 3 == 0) ? 19 : 5)] :
          sel < 8 ? 8'hF0 : sel == 8 ? 8'hE0 : 8'($urandom_range(0, 255));
      r = $urandom_range(0, 249) == 0;
      if (!v && $urandom_range(0, 7) == 0) s = ~s;
      cyc(v, c, s, r);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
